// File: rtl/alu_arb_pkg.sv
// Shared constants and types for alu_share_arb: FSM states, ALU opcodes,
// per-requester control bit offsets and the registered flag layout.
package alu_arb_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned CTL_W   = 4;
  localparam int unsigned FLAG_W  = 8;
  localparam int unsigned OPER_W  = 3;

  localparam int unsigned CTL_INVA = 3;
  localparam int unsigned CTL_INVB = 2;
  localparam int unsigned CTL_CIN  = 1;
  localparam int unsigned CTL_SIGN = 0;

  localparam int unsigned FLG_SEQ  = 0;
  localparam int unsigned FLG_SLT  = 1;
  localparam int unsigned FLG_SLE  = 2;
  localparam int unsigned FLG_SCO  = 3;
  localparam int unsigned FLG_BEQZ = 4;
  localparam int unsigned FLG_BNEZ = 5;
  localparam int unsigned FLG_BLTZ = 6;
  localparam int unsigned FLG_BGEZ = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [OPER_W-1:0] {
    OP_ADD = 3'd0,
    OP_AND = 3'd1,
    OP_OR  = 3'd2,
    OP_XOR = 3'd3,
    OP_SLL = 3'd4,
    OP_SRL = 3'd5,
    OP_ROL = 3'd6,
    OP_ROR = 3'd7
  } oper_e;

  // One-hot grant; a lone requester always wins, tie_pref settles a tie.
  function automatic logic [NUM_REQ-1:0] arb_pick(input logic [NUM_REQ-1:0] valid,
                                                  input logic               tie_pref);
    logic [NUM_REQ-1:0] grant;
    grant = valid;
    if (&valid) begin
      grant = tie_pref ? NUM_REQ'(2) : NUM_REQ'(1);
    end
    return grant;
  endfunction

endpackage

// File: rtl/alu_share_arb_alu.sv
// Team 16-bit ALU: optional operand inversion, add/logic/shift/rotate on
// Oper, bit-reversed InA, and compare/branch flags from the adder result.
module alu_share_arb_alu
  import alu_arb_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH  = 16,
  parameter int unsigned NUM_OPERATIONS = 3
) (
  input  logic [OPERAND_WIDTH-1:0]  in_a_i,
  input  logic [OPERAND_WIDTH-1:0]  in_b_i,
  input  logic [NUM_OPERATIONS-1:0] oper_i,
  input  logic [CTL_W-1:0]          ctl_i,
  output logic [OPERAND_WIDTH-1:0]  alu_out_c,
  output logic [OPERAND_WIDTH-1:0]  btr_out_c,
  output logic [FLAG_W-1:0]         flags_c
);

  localparam int unsigned MSB  = OPERAND_WIDTH - 1;
  localparam int unsigned SH_W = $clog2(OPERAND_WIDTH);

  logic [OPERAND_WIDTH-1:0] op_a;
  logic [OPERAND_WIDTH-1:0] op_b;
  logic [OPERAND_WIDTH-1:0] sum;
  logic                     carry;
  logic                     ovf;
  logic                     lt;
  logic                     eq;
  logic [SH_W-1:0]          sh;
  logic [SH_W:0]            sh_inv;

  assign op_a = ctl_i[CTL_INVA] ? ~in_a_i : in_a_i;
  assign op_b = ctl_i[CTL_INVB] ? ~in_b_i : in_b_i;

  assign {carry, sum} = {1'b0, op_a} + {1'b0, op_b} + (OPERAND_WIDTH+1)'(ctl_i[CTL_CIN]);

  // Signed less-than is the true sign of the sum: result MSB corrected by overflow.
  assign ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
  assign lt  = ctl_i[CTL_SIGN] ? (sum[MSB] ^ ovf) : ~carry;
  assign eq  = ~|sum;

  assign sh     = op_b[SH_W-1:0];
  assign sh_inv = (SH_W+1)'(OPERAND_WIDTH) - {1'b0, sh};

  always_comb begin
    alu_out_c = '0;
    case (oper_i)
      NUM_OPERATIONS'(OP_ADD): alu_out_c = sum;
      NUM_OPERATIONS'(OP_AND): alu_out_c = op_a & op_b;
      NUM_OPERATIONS'(OP_OR):  alu_out_c = op_a | op_b;
      NUM_OPERATIONS'(OP_XOR): alu_out_c = op_a ^ op_b;
      NUM_OPERATIONS'(OP_SLL): alu_out_c = op_a << sh;
      NUM_OPERATIONS'(OP_SRL): alu_out_c = op_a >> sh;
      NUM_OPERATIONS'(OP_ROL): alu_out_c = (op_a << sh) | (op_a >> sh_inv);
      NUM_OPERATIONS'(OP_ROR): alu_out_c = (op_a >> sh) | (op_a << sh_inv);
      default:                 alu_out_c = '0;
    endcase
  end

  always_comb begin
    btr_out_c = '0;
    for (int i = 0; i < int'(OPERAND_WIDTH); i++) begin
      btr_out_c[i] = in_a_i[int'(MSB) - i];
    end
  end

  // Branch flags test raw InA; set-flags come from the adder.
  always_comb begin
    flags_c           = '0;
    flags_c[FLG_SEQ]  = eq;
    flags_c[FLG_SLT]  = lt;
    flags_c[FLG_SLE]  = lt | eq;
    flags_c[FLG_SCO]  = carry;
    flags_c[FLG_BEQZ] = ~|in_a_i;
    flags_c[FLG_BNEZ] = |in_a_i;
    flags_c[FLG_BLTZ] = in_a_i[MSB];
    flags_c[FLG_BGEZ] = ~in_a_i[MSB];
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one alu_share_arb_alu between two requesters: arbitrate, latch, execute, respond.
// ALU_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins ties); default is round-robin.
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH  = 16,
  parameter int unsigned NUM_OPERATIONS = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0]    req_a,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0]    req_b,
  input  logic [NUM_REQ*NUM_OPERATIONS-1:0]   req_oper,
  input  logic [NUM_REQ*CTL_W-1:0]            req_ctl,
  output logic                                resp_valid,
  input  logic                                resp_ready,
  output logic                                resp_id,
  output logic [OPERAND_WIDTH-1:0]            resp_aluout,
  output logic [OPERAND_WIDTH-1:0]            resp_btrout,
  output logic [FLAG_W-1:0]                   resp_flags,
  output logic                                busy
);

  localparam int unsigned W = OPERAND_WIDTH;
  localparam int unsigned N = NUM_OPERATIONS;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_vec;
  logic               grant_id;
  logic               accept;
  logic               tie_pref;

  logic [W-1:0]       a_q, b_q;
  logic [N-1:0]       oper_q;
  logic [CTL_W-1:0]   ctl_q;
  logic               id_q;

  logic               resp_id_q;
  logic [W-1:0]       resp_aluout_q, resp_btrout_q;
  logic [FLAG_W-1:0]  resp_flags_q;

  logic [W-1:0]       alu_out;
  logic [W-1:0]       btr_out;
  logic [FLAG_W-1:0]  alu_flags;

  // Next-state and grant decode
  always_comb begin
    state_d   = state_q;
    grant_vec = '0;
    grant_id  = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_vec = arb_pick(req_valid, tie_pref);
          grant_id  = grant_vec[1];
          accept    = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant is visible only while out of reset so nothing looks accepted during it.
  assign req_ready = rst ? grant_vec : '0;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign tie_pref = 1'b0;
`else
  logic rr_ptr_q, rr_ptr_d;

  assign rr_ptr_d = accept ? ~grant_id : rr_ptr_q;
  assign tie_pref = rr_ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand registers: the ALU sees only these, never the live request buses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      oper_q <= '0;
      ctl_q  <= '0;
      id_q   <= 1'b0;
    end else if (accept) begin
      a_q    <= grant_id ? req_a[2*W-1:W]         : req_a[W-1:0];
      b_q    <= grant_id ? req_b[2*W-1:W]         : req_b[W-1:0];
      oper_q <= grant_id ? req_oper[2*N-1:N]      : req_oper[N-1:0];
      ctl_q  <= grant_id ? req_ctl[2*CTL_W-1:CTL_W] : req_ctl[CTL_W-1:0];
      id_q   <= grant_id;
    end
  end

  alu_share_arb_alu #(
    .OPERAND_WIDTH  (OPERAND_WIDTH),
    .NUM_OPERATIONS (NUM_OPERATIONS)
  ) u_alu (
    .in_a_i    (a_q),
    .in_b_i    (b_q),
    .oper_i    (oper_q),
    .ctl_i     (ctl_q),
    .alu_out_c (alu_out),
    .btr_out_c (btr_out),
    .flags_c   (alu_flags)
  );

  // Result capture at the end of EXEC; held untouched through RESP backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_id_q     <= 1'b0;
      resp_aluout_q <= '0;
      resp_btrout_q <= '0;
      resp_flags_q  <= '0;
    end else if (state_q == EXEC) begin
      resp_id_q     <= id_q;
      resp_aluout_q <= alu_out;
      resp_btrout_q <= btr_out;
      resp_flags_q  <= alu_flags;
    end
  end

  assign resp_valid  = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign resp_id     = resp_id_q;
  assign resp_aluout = resp_aluout_q;
  assign resp_btrout = resp_btrout_q;
  assign resp_flags  = resp_flags_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_alu_share_arb;
  import alu_arb_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned NO = 3;

  typedef struct packed {
    logic [W-1:0] alu;
    logic [W-1:0] btr;
    logic [7:0]   flg;
  } res_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        req_valid = '0;
  logic [1:0]        req_ready;
  logic [2*W-1:0]    req_a = '0;
  logic [2*W-1:0]    req_b = '0;
  logic [2*NO-1:0]   req_oper = '0;
  logic [7:0]        req_ctl = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic              resp_id;
  logic [W-1:0]      resp_aluout;
  logic [W-1:0]      resp_btrout;
  logic [7:0]        resp_flags;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.OPERAND_WIDTH(W), .NUM_OPERATIONS(NO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_oper    (req_oper),
    .req_ctl     (req_ctl),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_aluout (resp_aluout),
    .resp_btrout (resp_btrout),
    .resp_flags  (resp_flags),
    .busy        (busy)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference ALU from the arithmetic definition of each operation.
  function automatic res_t alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] op, input logic [3:0] ctl);
    res_t        r;
    logic [15:0] xa, yb, t;
    int unsigned u;
    int          s;
    int          sh;
    logic        slt, seq;
    xa = ctl[3] ? ~a : a;
    yb = ctl[2] ? ~b : b;
    u  = 32'(xa) + 32'(yb) + 32'(ctl[1]);
    s  = int'($signed(xa)) + int'($signed(yb)) + int'({31'd0, ctl[1]});
    seq = (u % 65536) == 0;
    slt = ctl[0] ? (s < 0) : (u < 65536);
    sh  = int'(yb[3:0]);
    t   = xa;
    for (int i = 0; i < sh; i++) begin
      if (op == 3'd4) t = {t[14:0], 1'b0};
      if (op == 3'd5) t = {1'b0, t[15:1]};
      if (op == 3'd6) t = {t[14:0], t[15]};
      if (op == 3'd7) t = {t[0], t[15:1]};
    end
    case (op)
      3'd0:    r.alu = 16'(u);
      3'd1:    r.alu = xa & yb;
      3'd2:    r.alu = xa | yb;
      3'd3:    r.alu = xa ^ yb;
      default: r.alu = t;
    endcase
    for (int i = 0; i < 16; i++) r.btr[15-i] = a[i];
    r.flg = {~a[15], a[15], (a != 0), (a == 0), (u >= 65536), (slt | seq), slt, seq};
    return r;
  endfunction

  function automatic int pick(input logic [1:0] v, input int pref);
    if (v == 2'b11) return pref;
    if (v == 2'b10) return 1;
    if (v == 2'b01) return 0;
    return -1;
  endfunction

  // Transaction model: m_age <0 free, 0 executing, >=1 response outstanding.
  int   m_age  = -1;
  int   m_pref = 0;
  res_t m_pend, m_shown;
  logic m_pend_id, m_shown_id;

  always @(negedge clk) begin
    int         g;
    logic [1:0] exp_rdy;
    if (!rst) begin
      m_age = -1; m_pref = 0; m_shown = '0; m_shown_id = 1'b0;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_resp_id", 32'(resp_id), 0);
      chk("rst_aluout", 32'(resp_aluout), 0);
      chk("rst_btrout", 32'(resp_btrout), 0);
      chk("rst_flags", 32'(resp_flags), 0);
    end else begin
      g       = (m_age < 0) ? pick(req_valid, m_pref) : -1;
      exp_rdy = (g < 0) ? 2'b00 : 2'(1 << g);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("resp_valid", 32'(resp_valid), 32'(m_age >= 1));
      chk("busy", 32'(busy), 32'(m_age >= 0));
      chk("resp_id", 32'(resp_id), 32'(m_shown_id));
      chk("resp_aluout", 32'(resp_aluout), 32'(m_shown.alu));
      chk("resp_btrout", 32'(resp_btrout), 32'(m_shown.btr));
      chk("resp_flags", 32'(resp_flags), 32'(m_shown.flg));
      if (g >= 0) begin
        m_pend    = alu_ref(req_a[g*W +: W], req_b[g*W +: W], req_oper[g*NO +: NO], req_ctl[g*4 +: 4]);
        m_pend_id = g[0];
        m_age     = 0;
`ifndef ALU_ARB_FIXED_PRIO_EN
        m_pref    = 1 - g;
`endif
      end else if (m_age == 0) begin
        m_age      = 1;
        m_shown    = m_pend;
        m_shown_id = m_pend_id;
      end else if (m_age >= 1 && resp_ready) begin
        m_age = -1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input logic [3:0] ctl);
    req_a[r*W +: W]     = a;
    req_b[r*W +: W]     = b;
    req_oper[r*NO +: NO] = op;
    req_ctl[r*4 +: 4]   = ctl;
  endtask

  task automatic wait_resp(input string nm);
    int t;
    t = 0;
    while (!resp_valid && t < 12) begin
      step();
      t++;
    end
    if (!resp_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: resp_valid never rose within 12 cycles", nm);
    end
  endtask

  initial begin
    logic [1:0] acc;
    int         grants[4];
    int         exp_g[4];
    int         g1_cnt, rsp_cnt;

    step();
    step();
    chk("init_busy", 32'(busy), 0);
    rst = 1'b1;
    step();

    // Single add from req0 with the exact accept-to-response timing.
    set_req(0, 16'h0003, 16'h0004, 3'd0, 4'h0);
    req_valid = 2'b01;
    #1;
    chk("add_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    chk("add_not_early", 32'(resp_valid), 0);
    step();
    chk("add_resp_valid", 32'(resp_valid), 1);
    chk("add_aluout", 32'(resp_aluout), 32'h0007);
    chk("add_id", 32'(resp_id), 0);

    // Backpressure: five cycles held, pending requests must not be accepted.
    set_req(0, 16'h1111, 16'h2222, 3'd1, 4'h0);
    set_req(1, 16'h3333, 16'h4444, 3'd2, 4'h0);
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(resp_valid), 1);
      chk("bp_aluout", 32'(resp_aluout), 32'h0007);
      chk("bp_ready", 32'(req_ready), 0);
    end
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("bp_release_valid", 32'(resp_valid), 0);
    chk("bp_release_busy", 32'(busy), 0);

    // Compare from req1: 5 - 5 signed.
    set_req(1, 16'h0005, 16'h0005, 3'd0, 4'b0111);
    req_valid = 2'b10;
    #1;
    chk("cmp_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;
    wait_resp("cmp_wait");
    chk("cmp_seq", 32'(resp_flags[FLG_SEQ]), 1);
    chk("cmp_sle", 32'(resp_flags[FLG_SLE]), 1);
    chk("cmp_slt", 32'(resp_flags[FLG_SLT]), 0);
    chk("cmp_flags", 32'(resp_flags), 32'hAD);
    chk("cmp_id", 32'(resp_id), 1);
    resp_ready = 1'b1;
    step();

    // req1 raises valid while busy and withdraws before it can be accepted.
    set_req(0, 16'h0010, 16'h0001, 3'd4, 4'h0);
    req_valid = 2'b01;
    step();
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    g1_cnt = 0;
    rsp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (req_ready[1]) g1_cnt++;
      if (resp_valid) begin
        rsp_cnt++;
        chk("wd_resp_id", 32'(resp_id), 0);
        chk("wd_aluout", 32'(resp_aluout), 32'h0020);
      end
      step();
    end
    chk("wd_req1_grants", 32'(g1_cnt), 0);
    chk("wd_resp_count", 32'(rsp_cnt), 1);

    // Reset while a response is pending.
    resp_ready = 1'b0;
    set_req(0, 16'h00F0, 16'h0F00, 3'd0, 4'h0);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    wait_resp("rst_wait");
    chk("pre_rst_aluout", 32'(resp_aluout), 32'h0FF0);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(resp_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_aluout", 32'(resp_aluout), 0);
    chk("mid_rst_flags", 32'(resp_flags), 0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 0);

    // Tie arbitration from a fresh reset.
    set_req(0, 16'h0001, 16'h0001, 3'd0, 4'h0);
    set_req(1, 16'h0002, 16'h0002, 3'd3, 4'h0);
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      int t;
      t = 0;
      grants[k] = -1;
      while (req_ready == 2'b00 && t < 8) begin
        step();
        t++;
      end
      if (req_ready != 2'b00) grants[k] = int'(req_ready[1]);
      step();
    end
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    for (int k = 0; k < 4; k++) chk("tie_grant", 32'(grants[k]), 32'(exp_g[k]));
    req_valid = 2'b00;
    repeat (4) step();

    // Random traffic with holds, withdrawals, backpressure and one reset.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      rst = (c == 800) ? 1'b0 : 1'b1;
      for (int r = 0; r < 2; r++) begin
        if (req_valid[r] && acc[r]) req_valid[r] = 1'b0;
        if (!req_valid[r]) begin
          if ($urandom_range(0, 2) == 0) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            set_req(r, ra, rb, 3'($urandom_range(0, 7)), 4'($urandom));
            req_valid[r] = 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[r] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = 2'b00;
    resp_ready = 1'b1;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
